pipo_write_arbiter: RTL and testbench
=====================================

Name: pipo_write_arbiter

Overview:
- Two-requester write arbiter and sequencer for the shared 32-bit parallel-in/parallel-out register.
- Owns the register's load timing: grants one requester at a time (round-robin), loads that requester's word, then completes a four-phase req/ack handshake.
- Sits between requester blocks and the shared register; the register output is exported as q.

Parameters:
DATA_W, 32, width of the shared register and data buses
CNT_W, 8, width of the completed-write counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 write request, level, held until ack0
data0  input  DATA_W  requester 0 write data, stable while req0 high
ack0  output  1  requester 0 write complete
req1  input  1  requester 1 write request, level, held until ack1
data1  input  DATA_W  requester 1 write data, stable while req1 high
ack1  output  1  requester 1 write complete
q  output  DATA_W  shared register contents
busy  output  1  high in any state other than IDLE
grant_id  output  1  requester currently or last granted
wr_count  output  CNT_W  number of completed writes, modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous):
  - q=0, ack0=ack1=0, busy=0, grant_id=0, wr_count=0.
  - State=IDLE; round-robin pointer rr=1, so requester 0 wins the first contention.
  - Reset mid-transaction abandons it: no ack, q=0, and the counter does not increment.
- FSM states: IDLE, LOAD, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Only one req high: grant that requester.
  - Both high: grant the requester opposite to rr.
  - On grant: capture the granted data into the staging register, set grant_id, go to LOAD.
- LOAD (exactly 1 cycle):
  - q <= staged data at the closing edge.
  - The ungranted requester's data is never sampled.
  - Go to ACK.
- ACK:
  - ack of grant_id is high (registered output); the other ack stays 0.
  - Remain while the granted req is high.
  - When the granted req is sampled low: ack drops at that edge, rr <= grant_id, wr_count increments, state returns to IDLE.
- Latency:
  - req sampled high in IDLE at edge t.
  - q updated at edge t+1.
  - ack high from edge t+2.
  - Minimum transaction is 4 cycles including the req-drop cycle.
- Ordering and fairness:
  - At most one ack is ever high.
  - q changes only at the LOAD->ACK edge.
  - A request arriving during busy waits; its req stays high, which is legal.
  - Under continuous contention, grants alternate 0,1,0,1.
- Requester dropping req before ack: protocol violation. The FSM still completes the load; ACK then exits on the first cycle that sees req low. The bench checks this but does not rely on it.
- wr_count wraps from 2^CNT_W-1 to 0 with no flag.
- busy = (state != IDLE), registered.

Test Plan:
- Reset check: assert rst_n=0 mid-sim -> q=0, ack0=ack1=0, busy=0, wr_count=0 immediately (asynchronous), with no clock edge needed.
- Single write: req0=1, data0=0xDEADBEEF -> q=0xDEADBEEF one edge after grant; ack0 high from the next edge; drop req0 -> ack0=0, wr_count=1, busy=0.
- Simultaneous contention after reset: req0=req1=1, data0=0x11111111, data1=0x22222222 -> q=0x11111111 and ack0 first. Then q=0x22222222 and ack1. Each requester drops req after its ack; ack1 never high during the first transaction.
- Sustained contention: both requesters re-request immediately for 6 transactions -> grant_id sequence 0,1,0,1,0,1; wr_count=6.
- Reset during LOAD: req1=1, data1=0xCAFEF00D, pulse rst_n low in the LOAD cycle -> q=0, no ack1 pulse, wr_count=0. After release with req1 still high, the full transaction restarts.
- Counter wrap: 256 back-to-back req0 writes with incrementing data -> wr_count returns to 0; q holds the last data value (0x000000FF).

Source files
------------

// File: rtl/pipo_write_arbiter.sv
// Round-robin write arbiter for a shared DATA_W-bit parallel-in/parallel-out register.
// Grants one of two requesters, loads its word into q, then completes a four-phase req/ack handshake.
module pipo_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              grant_id,
    output logic [CNT_W-1:0]  wr_count
);

    // Handshake: a requester raises reqN with dataN stable and holds both until ackN
    // is seen high; it then drops reqN, and ackN falls on the edge that samples reqN low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state;
    logic              rr;
    logic [DATA_W-1:0] staged;
    logic              pick;
    logic              granted_req;

    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~rr;
        end else if (req1) begin
            pick = 1'b1;
        end
        granted_req = grant_id ? req1 : req0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= 1'b1;
            staged   <= '0;
            q        <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_id <= pick;
                        staged   <= pick ? data1 : data0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    q     <= staged;
                    state <= ACK;
                end
                ACK: begin
                    // A requester that dropped req early still gets its load; we just exit here.
                    if (!granted_req) begin
                        ack0     <= 1'b0;
                        ack1     <= 1'b0;
                        rr       <= grant_id;
                        wr_count <= wr_count + CNT_W'(1);
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        ack0 <= ~grant_id;
                        ack1 <= grant_id;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Bench for pipo_write_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requester traffic.
module tb_pipo_write_arbiter;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [DATA_W-1:0] data0 = '0;
    logic [DATA_W-1:0] data1 = '0;
    logic              ack0, ack1, busy, grant_id;
    logic [DATA_W-1:0] q;
    logic [CNT_W-1:0]  wr_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    pipo_write_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .data0    (data0),
        .ack0     (ack0),
        .req1     (req1),
        .data1    (data1),
        .ack1     (ack1),
        .q        (q),
        .busy     (busy),
        .grant_id (grant_id),
        .wr_count (wr_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: a transaction is "active" from grant; its age counts edges since grant
    bit                m_active = 1'b0;
    int                m_age    = 0;
    bit                m_rr     = 1'b1;
    bit                m_gid    = 1'b0;
    logic [DATA_W-1:0] m_staged = '0;
    logic [DATA_W-1:0] m_q      = '0;
    int                m_cnt    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_age    = 0;
            m_rr     = 1'b1;
            m_gid    = 1'b0;
            m_staged = '0;
            m_q      = '0;
            m_cnt    = 0;
        end else if (!m_active) begin
            if (req0 || req1) begin
                if (req0 && req1) m_gid = !m_rr;
                else              m_gid = req1;
                m_staged = m_gid ? data1 : data0;
                m_active = 1'b1;
                m_age    = 0;
            end
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_q = m_staged;
            end else if (!(m_gid ? req1 : req0)) begin
                m_active = 1'b0;
                m_rr     = m_gid;
                m_cnt    = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("cmp_q",        q,        m_q);
            check("cmp_ack0",     ack0,     m_active && m_age >= 2 && m_gid == 1'b0);
            check("cmp_ack1",     ack1,     m_active && m_age >= 2 && m_gid == 1'b1);
            check("cmp_busy",     busy,     m_active);
            check("cmp_grant_id", grant_id, m_gid);
            check("cmp_wr_count", wr_count, m_cnt);
        end
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_q",        q,        32'h0);
        check("rst_ack0",     ack0,     1'b0);
        check("rst_ack1",     ack1,     1'b0);
        check("rst_busy",     busy,     1'b0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_wr_count", wr_count, 8'h0);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_ack(input bit who, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (who ? ack1 : ack0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic random_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (req0 && ack0) begin
                if ($urandom_range(1, 0) == 1) req0 = 1'b0;
            end else if (!req0 && !ack0 && $urandom_range(2, 0) == 0) begin
                req0  = 1'b1;
                data0 = $urandom;
            end
            if (req1 && ack1) begin
                if ($urandom_range(1, 0) == 1) req1 = 1'b0;
            end else if (!req1 && !ack1 && $urandom_range(2, 0) == 0) begin
                req1  = 1'b1;
                data1 = $urandom;
            end
        end
    endtask

    initial begin
        bit ok;
        bit any;
        bit g;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // single write, cycle-exact
        @(negedge clk);
        req0  = 1'b1;
        data0 = 32'hDEADBEEF;
        @(negedge clk);
        check("single_busy", busy, 1'b1);
        check("single_q_pre", q, 32'h0);
        @(negedge clk);
        check("single_q", q, 32'hDEADBEEF);
        check("single_ack_early", ack0, 1'b0);
        @(negedge clk);
        check("single_ack0", ack0, 1'b1);
        check("single_ack1", ack1, 1'b0);
        req0 = 1'b0;
        @(negedge clk);
        check("single_ack_drop", ack0, 1'b0);
        check("single_count", wr_count, 8'd1);
        check("single_idle", busy, 1'b0);

        // requester drops req before ack: load still happens, no ack
        req1  = 1'b1;
        data1 = 32'hA5A5A5A5;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        check("early_q", q, 32'hA5A5A5A5);
        check("early_busy", busy, 1'b1);
        @(negedge clk);
        check("early_ack1", ack1, 1'b0);
        check("early_idle", busy, 1'b0);
        check("early_count", wr_count, 8'd2);

        // some traffic, then an asynchronous reset mid-run
        random_traffic(40);
        do_reset();

        // simultaneous contention after reset
        @(negedge clk);
        req0  = 1'b1;
        data0 = 32'h11111111;
        req1  = 1'b1;
        data1 = 32'h22222222;
        wait_ack(1'b0, 10, ok);
        check("cont_ack0_seen", ok, 1'b1);
        check("cont_q0", q, 32'h11111111);
        check("cont_ack1_quiet", ack1, 1'b0);
        req0 = 1'b0;
        wait_ack(1'b1, 10, ok);
        check("cont_ack1_seen", ok, 1'b1);
        check("cont_q1", q, 32'h22222222);
        check("cont_ack0_quiet", ack0, 1'b0);
        req1 = 1'b0;
        @(negedge clk);
        check("cont_count", wr_count, 8'd2);

        // sustained contention: grants alternate starting with 0
        do_reset();
        @(negedge clk);
        req0  = 1'b1;
        data0 = $urandom;
        req1  = 1'b1;
        data1 = $urandom;
        for (int k = 0; k < 6; k++) begin
            any = 1'b0;
            for (int i = 0; i < 20 && !any; i++) begin
                @(negedge clk);
                any = ack0 || ack1;
            end
            check("sus_ack_seen", any, 1'b1);
            check("sus_grant", grant_id, k % 2);
            g = grant_id;
            if (k < 5) begin
                if (g) req1 = 1'b0; else req0 = 1'b0;
                @(negedge clk);
                if (g) begin
                    req1  = 1'b1;
                    data1 = $urandom;
                end else begin
                    req0  = 1'b1;
                    data0 = $urandom;
                end
            end else begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        @(negedge clk);
        check("sus_count", wr_count, 8'd6);
        check("sus_idle", busy, 1'b0);

        // reset during LOAD abandons the write, then it restarts
        do_reset();
        @(negedge clk);
        req1  = 1'b1;
        data1 = 32'hCAFEF00D;
        @(negedge clk);
        check("rload_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rload_q", q, 32'h0);
        check("rload_ack1", ack1, 1'b0);
        check("rload_busy0", busy, 1'b0);
        check("rload_count", wr_count, 8'd0);
        #1 rst_n = 1'b1;
        wait_ack(1'b1, 10, ok);
        check("rload_restart_ack", ok, 1'b1);
        check("rload_restart_q", q, 32'hCAFEF00D);
        check("rload_count_mid", wr_count, 8'd0);
        req1 = 1'b0;
        @(negedge clk);
        check("rload_count_done", wr_count, 8'd1);

        // counter wrap: 256 writes from requester 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            req0  = 1'b1;
            data0 = i;
            wait_ack(1'b0, 10, ok);
            check("wrap_ack", ok, 1'b1);
            req0 = 1'b0;
            @(negedge clk);
        end
        check("wrap_count", wr_count, 8'd0);
        check("wrap_q", q, 32'h000000FF);

        // randomized traffic against the model
        do_reset();
        random_traffic(3000);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
